// File: rtl/i2c_pkg.sv
// i2c_pkg: state encoding and bus constants shared by the I2C master control FSM
package i2c_pkg;
  typedef logic [3:0] state_t;
  localparam state_t IDLE       = 4'd0;
  localparam state_t START      = 4'd1;
  localparam state_t ADDR       = 4'd2;
  localparam state_t ADDR_ACK   = 4'd3;
  localparam state_t WRITE_DATA = 4'd4;
  localparam state_t WRITE_ACK  = 4'd5;
  localparam state_t READ_DATA  = 4'd6;
  localparam state_t READ_ACK   = 4'd7;
  localparam state_t STOP_A     = 4'd8;
  localparam state_t STOP_B     = 4'd9;
  localparam logic ACK     = 1'b0;
  localparam logic NACK    = 1'b1;
  localparam logic RW_READ = 1'b1;
endpackage

// File: rtl/i2c_bit_counter.sv
// i2c_bit_counter: MSB-first bit index with reload, saturating decrement and zero flag
module i2c_bit_counter #(
  parameter logic [3:0] LOAD_VAL = 4'd7
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic       i_dec,
  output logic [3:0] o_cnt,
  output logic       o_zero
);
  logic [3:0] r_cnt;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_cnt <= '0;
    else if (i_load) r_cnt <= LOAD_VAL;
    else if (i_dec && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
  assign o_cnt  = r_cnt;
  assign o_zero = r_cnt == 4'd0;
endmodule

// File: rtl/i2c_master_fsm.sv
// i2c_master_fsm: sequences START, address, ACK, data bytes and STOP with registered strobes
module i2c_master_fsm
  import i2c_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 8,
  parameter int LEN_SIZE  = 8
) (
  input  logic                 i2c_core_clk_i,
  input  logic                 reset_ni,
  input  logic                 enable_i,
  input  logic [ADDR_SIZE-1:0] addr_i,
  input  logic [LEN_SIZE-1:0]  byte_count_i,
  input  logic                 tx_fifo_empty_i,
  input  logic                 rx_fifo_full_i,
  input  logic                 i2c_sda_i,
  output logic                 sda_low_en_o,
  output logic                 write_addr_en_o,
  output logic                 write_data_en_o,
  output logic                 receive_data_en_o,
  output logic [3:0]           count_bit_o,
  output logic                 sda_oe_o,
  output logic                 scl_en_o,
  output logic                 tx_fifo_rd_en_o,
  output logic                 rx_fifo_wr_en_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 ack_error_o
);
  state_t r_state, w_next;
  logic r_rw, r_ack_err;
  logic [LEN_SIZE-1:0] r_len, w_len_dec;
  logic [3:0] w_cnt;
  logic w_zero, w_load, w_dec, w_start, w_nack, w_unused;
  logic r_sda_low, r_wr_addr, r_wr_data, r_rcv, r_oe, r_scl, r_tx_rd, r_rx_wr, r_busy, r_done;
  logic w_sda_low, w_wr_addr, w_wr_data, w_rcv, w_oe, w_scl, w_tx_rd, w_rx_wr, w_busy, w_done;
  assign w_unused  = ^addr_i[ADDR_SIZE-1:1];
  assign w_start   = r_state == IDLE && enable_i;
  assign w_nack    = i2c_sda_i == NACK;
  assign w_load    = r_state inside {START, ADDR_ACK, WRITE_ACK, READ_ACK};
  assign w_dec     = r_state inside {ADDR, WRITE_DATA, READ_DATA};
  assign w_len_dec = (r_state inside {WRITE_DATA, READ_DATA} && w_zero && r_len != '0)
                   ? r_len - LEN_SIZE'(1) : r_len;
  i2c_bit_counter #(.LOAD_VAL(4'(DATA_SIZE - 1))) u_bit_counter (
    .i_clk  (i2c_core_clk_i),
    .i_rst_n(reset_ni),
    .i_load (w_load),
    .i_dec  (w_dec),
    .o_cnt  (w_cnt),
    .o_zero (w_zero)
  );
  always_ff @(posedge i2c_core_clk_i or negedge reset_ni)
    if (!reset_ni) begin
      r_state   <= IDLE;
      r_rw      <= 1'b0;
      r_len     <= '0;
      r_ack_err <= 1'b0;
      r_sda_low <= 1'b0;
      r_wr_addr <= 1'b0;
      r_wr_data <= 1'b0;
      r_rcv     <= 1'b0;
      r_oe      <= 1'b0;
      r_scl     <= 1'b0;
      r_tx_rd   <= 1'b0;
      r_rx_wr   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_rw      <= w_start ? addr_i[0] : r_rw;
      r_len     <= w_start ? byte_count_i : w_len_dec;
      r_ack_err <= w_start ? 1'b0 : (r_state inside {ADDR_ACK, WRITE_ACK} && w_nack) ? 1'b1 : r_ack_err;
      r_sda_low <= w_sda_low;
      r_wr_addr <= w_wr_addr;
      r_wr_data <= w_wr_data;
      r_rcv     <= w_rcv;
      r_oe      <= w_oe;
      r_scl     <= w_scl;
      r_tx_rd   <= w_tx_rd;
      r_rx_wr   <= w_rx_wr;
      r_busy    <= w_busy;
      r_done    <= w_done;
    end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:       w_next = enable_i ? START : IDLE;
      START:      w_next = ADDR;
      ADDR:       w_next = w_zero ? ADDR_ACK : ADDR;
      ADDR_ACK:   w_next = (w_nack || r_len == '0) ? STOP_A
                         : (r_rw == RW_READ) ? READ_DATA
                         : tx_fifo_empty_i ? STOP_A : WRITE_DATA;
      WRITE_DATA: w_next = w_zero ? WRITE_ACK : WRITE_DATA;
      WRITE_ACK:  w_next = (w_nack || r_len == '0 || tx_fifo_empty_i) ? STOP_A : WRITE_DATA;
      READ_DATA:  w_next = w_zero ? READ_ACK : READ_DATA;
      READ_ACK:   w_next = r_sda_low ? READ_DATA : STOP_A;
      STOP_A:     w_next = STOP_B;
      STOP_B:     w_next = IDLE;
      default:    w_next = IDLE;
    endcase
  end
  // Outputs are decoded from the state being entered so they are valid for that whole cycle;
  // the master ACK decision is fixed on entry to READ_ACK and also steers its exit.
  always_comb begin
    w_sda_low = 1'b0;
    w_wr_addr = 1'b0;
    w_wr_data = 1'b0;
    w_rcv     = 1'b0;
    w_oe      = 1'b0;
    w_tx_rd   = 1'b0;
    w_rx_wr   = 1'b0;
    case (w_next)
      START, STOP_A: begin
        w_sda_low = 1'b1;
        w_oe      = 1'b1;
      end
      ADDR: begin
        w_wr_addr = 1'b1;
        w_oe      = 1'b1;
      end
      WRITE_DATA: begin
        w_wr_data = 1'b1;
        w_oe      = 1'b1;
        w_tx_rd   = r_state == WRITE_DATA && w_cnt == 4'd1;
      end
      READ_DATA: w_rcv = 1'b1;
      READ_ACK: begin
        w_rx_wr   = 1'b1;
        w_sda_low = w_len_dec != '0 && !rx_fifo_full_i;
        w_oe      = w_len_dec != '0 && !rx_fifo_full_i;
      end
      default: ;
    endcase
    w_scl  = w_next inside {ADDR, ADDR_ACK, WRITE_DATA, WRITE_ACK, READ_DATA, READ_ACK};
    w_busy = w_next != IDLE;
    w_done = r_state == STOP_B;
  end
  assign sda_low_en_o      = r_sda_low;
  assign write_addr_en_o   = r_wr_addr;
  assign write_data_en_o   = r_wr_data;
  assign receive_data_en_o = r_rcv;
  assign count_bit_o       = w_cnt;
  assign sda_oe_o          = r_oe;
  assign scl_en_o          = r_scl;
  assign tx_fifo_rd_en_o   = r_tx_rd;
  assign rx_fifo_wr_en_o   = r_rx_wr;
  assign busy_o            = r_busy;
  assign done_o            = r_done;
  assign ack_error_o       = r_ack_err;
endmodule

// File: tb/tb_i2c_master_fsm.sv
// tb_i2c_master_fsm: transaction-level trace model checked cycle by cycle against the FSM
module tb_i2c_master_fsm;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, sda = 1'b1, txe = 1'b1, rxf = 1'b0;
  logic [7:0] addr = '0, bc = '0;
  logic sda_low_en, wr_addr_en, wr_data_en, rcv_en, sda_oe, scl_en, tx_rd, rx_wr, busy, done, ack_err;
  logic [3:0] cnt;
  int errors = 0, checks = 0;
  typedef struct packed {logic sl, wa, wd, rc, oe, scl, txr, rxw, busy, done, err; logic [3:0] cnt;} obs_t;
  typedef struct packed {logic en, sda, txe, rxf;} stim_t;
  typedef struct {logic [7:0] addr; int len, txn, nack_at, full_at;} vec_t;
  obs_t got, q_exp[$];
  stim_t q_stim[$];
  logic m_err = 1'b0;
  logic [3:0] m_cnt = '0;
  int done_cyc, rd_pulses, wr_pulses;
  vec_t tbl[8], rv;

  always #5 clk = ~clk;

  i2c_master_fsm dut (
    .i2c_core_clk_i(clk), .reset_ni(rst_n), .enable_i(en), .addr_i(addr), .byte_count_i(bc),
    .tx_fifo_empty_i(txe), .rx_fifo_full_i(rxf), .i2c_sda_i(sda),
    .sda_low_en_o(sda_low_en), .write_addr_en_o(wr_addr_en), .write_data_en_o(wr_data_en),
    .receive_data_en_o(rcv_en), .count_bit_o(cnt), .sda_oe_o(sda_oe), .scl_en_o(scl_en),
    .tx_fifo_rd_en_o(tx_rd), .rx_fifo_wr_en_o(rx_wr), .busy_o(busy), .done_o(done), .ack_error_o(ack_err)
  );
  assign got = {sda_low_en, wr_addr_en, wr_data_en, rcv_en, sda_oe, scl_en, tx_rd, rx_wr, busy, done, ack_err, cnt};

  function automatic obs_t mk(input bit sl, wa, wd, rc, oe, scl, txr, rxw, bsy, dn, input logic [3:0] c);
    return '{sl, wa, wd, rc, oe, scl, txr, rxw, bsy, dn, m_err, c};
  endfunction

  function automatic stim_t rs();
    return '{1'b1, 1'($urandom), 1'($urandom), 1'($urandom)};
  endfunction

  task automatic check(input string nm, input int c, input obs_t e);
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", nm, c, got, e);
    end
  endtask

  task automatic check_int(input string nm, input int g, input int e);
    checks++;
    if (g != e) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, g, e);
    end
  endtask

  // Expected per-cycle trace derived from the transaction's byte-level rules.
  task automatic build(input vec_t v);
    int left, tx, b;
    bit rw, nack, stop, full, mack;
    stim_t s;
    q_exp.delete();
    q_stim.delete();
    m_err = 1'b0;
    q_exp.push_back(mk(1,0,0,0,1,0,0,0,1,0,m_cnt)); q_stim.push_back(rs());
    for (int i = 0; i < 8; i++) begin
      q_exp.push_back(mk(0,1,0,0,1,1,0,0,1,0,4'(7-i))); q_stim.push_back(rs());
    end
    rw = v.addr[0]; left = v.len; tx = v.txn; nack = v.nack_at == 0;
    s = rs(); s.sda = nack; s.txe = tx == 0;
    q_exp.push_back(mk(0,0,0,0,0,1,0,0,1,0,4'd0)); q_stim.push_back(s);
    if (nack) m_err = 1'b1;
    stop = nack || left == 0 || (!rw && tx == 0);
    b = 1;
    while (!stop) begin
      if (!rw) begin
        for (int i = 0; i < 8; i++) begin
          q_exp.push_back(mk(0,0,1,0,1,1,i==7,0,1,0,4'(7-i))); q_stim.push_back(rs());
        end
        tx--; left--;
        nack = v.nack_at == b;
        s = rs(); s.sda = nack; s.txe = tx == 0;
        q_exp.push_back(mk(0,0,0,0,0,1,0,0,1,0,4'd0)); q_stim.push_back(s);
        if (nack) m_err = 1'b1;
        stop = nack || left == 0 || tx == 0;
      end else begin
        full = v.full_at != 0 && b >= v.full_at;
        for (int i = 0; i < 8; i++) begin
          s = rs();
          if (i == 7) s.rxf = full;
          q_exp.push_back(mk(0,0,0,1,0,1,0,0,1,0,4'(7-i))); q_stim.push_back(s);
        end
        left--;
        mack = left != 0 && !full;
        q_exp.push_back(mk(mack,0,0,0,mack,1,0,1,1,0,4'd0)); q_stim.push_back(rs());
        stop = !mack;
      end
      b++;
    end
    m_cnt = 4'd7;
    q_exp.push_back(mk(1,0,0,0,1,0,0,0,1,0,4'd7)); q_stim.push_back(rs());
    q_exp.push_back(mk(0,0,0,0,0,0,0,0,1,0,4'd7)); q_stim.push_back(rs());
    s = rs(); s.en = 1'b0;
    q_exp.push_back(mk(0,0,0,0,0,0,0,0,0,1,4'd7)); q_stim.push_back(s);
    q_exp.push_back(mk(0,0,0,0,0,0,0,0,0,0,4'd7)); q_stim.push_back(s);
  endtask

  task automatic run(input vec_t v, input string nm, input int upto);
    stim_t s;
    @(negedge clk);
    en = 1'b1; addr = v.addr; bc = 8'(v.len);
    sda = 1'($urandom); txe = 1'($urandom); rxf = 1'($urandom);
    done_cyc = -1; rd_pulses = 0; wr_pulses = 0;
    for (int j = 0; j < q_exp.size() && j < upto; j++) begin
      @(negedge clk);
      s = q_stim[j];
      en = s.en; sda = s.sda; txe = s.txe; rxf = s.rxf;
      addr = 8'($urandom); bc = 8'($urandom);
      check(nm, j + 1, q_exp[j]);
      if (done && done_cyc < 0) done_cyc = j + 1;
      rd_pulses += int'(tx_rd);
      wr_pulses += int'(rx_wr);
    end
  endtask

  initial begin
    tbl[0] = '{8'hA0, 2, 2, -1, 0};
    tbl[1] = '{8'h50, 2, 2,  0, 0};
    tbl[2] = '{8'hA1, 3, 0, -1, 0};
    tbl[3] = '{8'hA1, 4, 0, -1, 1};
    tbl[4] = '{8'hA0, 0, 3, -1, 0};
    tbl[5] = '{8'hA0, 2, 0, -1, 0};
    tbl[6] = '{8'hA0, 3, 3,  2, 0};
    tbl[7] = '{8'hA1, 0, 0, -1, 0};
    repeat (3) @(negedge clk);
    check("reset", 0, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_release", 0, '0);
    for (int k = 0; k < 8; k++) begin
      build(tbl[k]);
      run(tbl[k], $sformatf("vec%0d", k), 1000);
      if (k == 0) begin
        check_int("write2_done_cycle", done_cyc, 31);
        check_int("write2_tx_pops", rd_pulses, 2);
      end
      if (k == 2) check_int("read3_rx_pushes", wr_pulses, 3);
      if (k == 3) check_int("read_full_rx_pushes", wr_pulses, 1);
      if (k == 4 || k == 5) check_int($sformatf("vec%0d_fifo_pulses", k), rd_pulses + wr_pulses, 0);
    end
    for (int k = 0; k < 20; k++) begin
      rv = '{8'($urandom), $urandom_range(0, 4), $urandom_range(0, 4),
             int'($urandom_range(0, 6)) - 1, $urandom_range(0, 4)};
      build(rv);
      run(rv, $sformatf("rand%0d", k), 1000);
    end
    build(tbl[0]);
    run(tbl[0], "abort", 15);
    #1 rst_n = 1'b0;
    #1 m_cnt = 4'd0; m_err = 1'b0;
    check("abort_async", 0, '0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_idle", 0, '0);
    build(tbl[6]);
    run(tbl[6], "after_abort", 1000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/i2c_master_fsm.md
Name: i2c_master_fsm

Overview:
- Control FSM for the I2C master. It sits directly upstream of the I2C core data path.
- Sequences a transaction: START, address byte, ACK, N data bytes (write or read), STOP.
- Drives the data path's strobes (sda_low_en, write_addr_en, write_data_en, receive_data_en) and the count_bit index.
- Handshakes with the TX FIFO (first-word-fallthrough head on the data path's data input) and the RX FIFO. One bit per i2c_core_clk_i cycle; SCL gating is exported to the clock generator.

Parameters:
- DATA_SIZE, 8, data byte width (count_bit range DATA_SIZE-1..0).
- ADDR_SIZE, 8, address field width; bit 0 = R/W (1 = read).
- LEN_SIZE, 8, width of the transfer byte count.

Ports:
- i2c_core_clk_i  in  1  I2C core clock.
- reset_ni  in  1  asynchronous active-low reset.
- enable_i  in  1  start request, sampled in IDLE only.
- addr_i  in  ADDR_SIZE  slave address + R/W; same bus drives the data path.
- byte_count_i  in  LEN_SIZE  bytes to transfer; 0 = address-only probe.
- tx_fifo_empty_i  in  1  TX FIFO empty.
- rx_fifo_full_i  in  1  RX FIFO full.
- i2c_sda_i  in  1  SDA line sample (ACK detection).
- sda_low_en_o  out  1  force SDA low.
- write_addr_en_o  out  1  shift address bit count_bit_o.
- write_data_en_o  out  1  shift data bit count_bit_o.
- receive_data_en_o  out  1  capture SDA into bit count_bit_o.
- count_bit_o  out  4  current bit index, MSB first.
- sda_oe_o  out  1  1 = master drives SDA, 0 = released.
- scl_en_o  out  1  SCL toggling enabled.
- tx_fifo_rd_en_o  out  1  pop TX head, 1-cycle pulse.
- rx_fifo_wr_en_o  out  1  push data_from_sda, 1-cycle pulse.
- busy_o  out  1  high from START through STOP.
- done_o  out  1  1-cycle pulse on return to IDLE.
- ack_error_o  out  1  sticky NACK flag; cleared on next accepted enable_i.

Behaviour:
- Reset, asynchronous: state = IDLE; every output = 0; count_bit_o = 0; internal byte counter and R/W latch = 0. Applying reset mid-transaction aborts it immediately, with SDA released and SCL stopped.
- All outputs are registered and decoded from the state.
- enable_i is ignored when not in IDLE.
- States and transitions:
  - IDLE: if enable_i, latch rw = addr_i[0] and len = byte_count_i, clear ack_error_o, go to START.
  - START (1 cycle): sda_low_en_o = 1, sda_oe_o = 1, busy_o = 1; count_bit_o <= DATA_SIZE-1; go to ADDR.
  - ADDR (8 cycles): write_addr_en_o = 1, sda_oe_o = 1, scl_en_o = 1; count_bit_o decrements 7..0; at 0 go to ADDR_ACK.
  - ADDR_ACK (1 cycle): sda_oe_o = 0; sample i2c_sda_i.
    - 1 = NACK: set ack_error_o, go to STOP_A.
    - len == 0: go to STOP_A.
    - rw = 1: go to READ_DATA.
    - rw = 0 and tx_fifo_empty_i: go to STOP_A.
    - otherwise: go to WRITE_DATA.
    - count_bit_o reloads to 7 on every exit.
  - WRITE_DATA (8 cycles): write_data_en_o = 1, sda_oe_o = 1; count 7..0. tx_fifo_rd_en_o pulses in the count == 0 cycle. At 0, decrement len and go to WRITE_ACK.
  - WRITE_ACK (1 cycle): sda_oe_o = 0; sample i2c_sda_i.
    - NACK: set ack_error_o, go to STOP_A.
    - len == 0 or tx_fifo_empty_i: go to STOP_A.
    - otherwise: go to WRITE_DATA.
  - READ_DATA (8 cycles): receive_data_en_o = 1, sda_oe_o = 0; count 7..0. At 0, decrement len and go to READ_ACK.
  - READ_ACK (1 cycle): rx_fifo_wr_en_o = 1, because the byte is complete in the data path this cycle.
    - len != 0 and !rx_fifo_full_i: master ACK (sda_low_en_o = 1, sda_oe_o = 1), go to READ_DATA.
    - otherwise: master NACK (sda_oe_o = 0), go to STOP_A.
    - rx_fifo_full_i terminates the read early; it does not set ack_error_o.
  - STOP_A (1 cycle): sda_low_en_o = 1, sda_oe_o = 1, scl_en_o = 0 (SCL held high).
  - STOP_B (1 cycle): sda_oe_o = 0 (SDA rises, giving the STOP condition); next cycle go to IDLE with done_o = 1 and busy_o = 0.
- Latency: a write of N bytes takes 1 + 8 + 1 + 9N + 2 cycles from START to IDLE.
- count_bit_o holds its value outside shift states.
- len arithmetic is LEN_SIZE-bit unsigned and never wraps: a decrement happens only when len > 0.

Decomposition:
- Shared package i2c_pkg holds:
  - the state encoding localparams (IDLE, START, ADDR, ADDR_ACK, WRITE_DATA, WRITE_ACK, READ_DATA, READ_ACK, STOP_A, STOP_B);
  - the ACK = 0 / NACK = 1 constants;
  - the RW_READ = 1 constant.
- One sub-module, i2c_bit_counter: 4-bit down-counter with load-to-7, decrement enable and a zero flag.

Test Plan:
- Write 2 bytes, addr_i = 0xA0, byte_count_i = 2, slave ACKs all, TX holds 2 entries -> state order START, ADDR×8, ADDR_ACK, (WRITE_DATA×8, WRITE_ACK)×2, STOP_A, STOP_B; tx_fifo_rd_en_o pulses exactly twice; done_o at cycle 31; ack_error_o = 0.
- Address NACK, addr_i = 0x50, i2c_sda_i = 1 in ADDR_ACK -> ack_error_o = 1, no write/receive strobes, STOP_A next cycle, done_o pulse; the next enable_i clears ack_error_o.
- Read 3 bytes, addr_i = 0xA1 -> rx_fifo_wr_en_o pulses ×3; master ACK on bytes 1–2 (sda_low_en_o = 1), NACK on byte 3 (sda_oe_o = 0); count_bit_o sequence 7..0 in each READ_DATA.
- Read with rx_fifo_full_i asserted at the first READ_ACK, byte_count_i = 4 -> one push, master NACK, STOP; ack_error_o stays 0.
- byte_count_i = 0 probe, and a write with TX empty after ADDR_ACK -> both go straight to STOP_A; no FIFO pulses.
- reset_ni low during WRITE_DATA with count_bit_o = 3 -> all outputs 0 asynchronously; IDLE after release; enable_i while busy_o = 1 is ignored.
